// File: rtl/mux_nx1_pipe_if.sv
// rtl/mux_nx1_pipe_if.sv - upstream/downstream handshake bundle for mux_nx1_pipe
interface mux_nx1_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     sel;
  logic [N*WIDTH-1:0]   data_in;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_err;

  modport master (
    output in_valid, sel, data_in, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err
  );

  modport slave (
    input  in_valid, sel, data_in, flush, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N:1 channel select feeding a 2-entry skid buffer
module mux_nx1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  mux_nx1_pipe_if.slave     bus,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   head_data, skid_data, new_data;
  logic [SEL_W-1:0]   head_sel, skid_sel;
  logic               head_err, skid_err, new_err;
  logic               xfer, pop;
  logic               load_head, load_skid, head_from_skid;

  // in_ready is held low while reset is asserted, otherwise purely state-decoded
  assign bus.in_ready  = rst && (state_q != FULL);
  assign bus.out_valid = (state_q == ONE) || (state_q == FULL);
  assign bus.out_data  = head_data;
  assign bus.out_sel   = head_sel;
  assign bus.out_err   = head_err;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign pop     = bus.out_valid && bus.out_ready;
  assign new_err = (32'(bus.sel) >= N);

  // Out-of-range selects match no channel and yield zero data
  always_comb begin
    new_data = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(bus.sel) == k) new_data = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (xfer) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (xfer && !pop) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop && !xfer) begin
          state_d   = EMPTY;
        end else if (xfer && pop) begin
          load_head = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d        = EMPTY;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_data <= '0;
      head_sel  <= '0;
      head_err  <= 1'b0;
    end else if (load_head) begin
      head_data <= new_data;
      head_sel  <= bus.sel;
      head_err  <= new_err;
    end else if (head_from_skid) begin
      head_data <= skid_data;
      head_sel  <= skid_sel;
      head_err  <= skid_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else if (load_skid) begin
      skid_data <= new_data;
      skid_sel  <= bus.sel;
      skid_err  <= new_err;
    end
  end

  // Counts every accepted bad select, including ones a flush later discards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt <= 8'd0;
    else if (xfer && new_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - scoreboard bench for mux_nx1_pipe with N=3, SEL_W=2
module tb_mux_nx1_pipe;
  localparam int W   = 32;
  localparam int NCH = 3;
  localparam int SW  = 2;

  logic       clk;
  logic       rst;
  logic [7:0] err_cnt;

  mux_nx1_pipe_if #(.WIDTH(W), .N(NCH), .SEL_W(SW)) bus ();

  mux_nx1_pipe #(.WIDTH(W), .N(NCH), .SEL_W(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .err_cnt (err_cnt)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          err;
  } ent_t;

  ent_t q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   exp_err = 0;
  int   pops    = 0;
  int   accepts = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-low-phase, compares the presented head with the scoreboard front
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      chk("rst_head",      64'({bus.out_data, bus.out_sel, bus.out_err}), 64'd0);
      chk("rst_err_cnt",   64'(err_cnt), 64'd0);
    end else begin
      chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("err_cnt",   64'(err_cnt),       64'(exp_err));
      if (bus.out_valid && q.size() != 0) begin
        chk("head", 64'({bus.out_data, bus.out_sel, bus.out_err}), 64'(q[0]));
        if (bus.out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      if (bus.flush) q.delete();
    end
  end

  // Driver: one cycle of stimulus; the expected entry is pushed after the monitor has run
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic f, input logic ordy);
    logic [W-1:0] ch [NCH];
    logic         acc;
    ent_t         e;
    @(negedge clk);
    #1;
    for (int k = 0; k < NCH; k++) ch[k] = $urandom;
    if (int'(s) < NCH) ch[s] = d;
    for (int k = 0; k < NCH; k++) bus.data_in[k*W +: W] = ch[k];
    bus.in_valid  = v;
    bus.sel       = s;
    bus.flush     = f;
    bus.out_ready = ordy;
    acc    = v && bus.in_ready;
    e.sel  = s;
    e.err  = (int'(s) >= NCH);
    e.data = '0;
    if (!e.err) e.data = ch[s];
    #3;
    if (acc) begin
      accepts++;
      if (e.err && exp_err < 255) exp_err++;
      if (!f) q.push_back(e);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    rst = 1'b0;
    q.delete();
    exp_err = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #3;
  endtask

  initial begin
    int base_pops, base_acc;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.data_in   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #3;
    step(0, 0, 0, 0, 1);

    // single capture from channel 2
    step(1, 2, 32'hDEADBEEF, 0, 1);
    step(0, 0, 0, 0, 1);

    // fill to FULL under backpressure, offer a refused entry, then release
    step(1, 0, 32'h11, 0, 0);
    step(1, 0, 32'h22, 0, 0);
    step(1, 1, 32'h33, 0, 0);
    step(1, 1, 32'h33, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // out-of-range select
    step(1, 3, 32'h55, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("err_one", 64'(err_cnt), 64'd1);

    // flush while FULL with an entry on offer
    step(1, 0, 32'hA1, 0, 0);
    step(1, 1, 32'hA2, 0, 0);
    step(1, 2, 32'hBAD, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // streaming at full rate
    base_pops = pops;
    base_acc  = accepts;
    repeat (100) step(1, 2'($urandom_range(0, 2)), $urandom, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stream_accepts", 64'(accepts - base_acc), 64'd100);
    chk("stream_pops",    64'(pops - base_pops),   64'd100);

    // error counter saturation
    repeat (300) step(1, 3, $urandom, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("err_sat", 64'(err_cnt), 64'd255);

    // random mix including flushes
    async_reset();
    repeat (300) step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    repeat (3) step(0, 0, 0, 0, 1);
    chk("drained", 64'(q.size()), 64'd0);

    // asynchronous reset while FULL with a pop pending
    step(1, 0, 32'h77, 0, 0);
    step(1, 3, 32'h88, 0, 0);
    async_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
